// File: rtl/mem_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mem_defs                                                   |
// | Shared encodings for the data-memory access controller: size codes,  |
// | read/write strobe values, FSM states and small size helpers.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_defs;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACCESS       = 2'd1,
    RESP         = 2'd2,
    ACCESS_SPLIT = 2'd3
  } state_t;

  // Number of bytes touched by an access; the reserved code touches none.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_WORD: return 3'd4;
      SIZE_HALF: return 3'd2;
      SIZE_BYTE: return 3'd1;
      default:   return 3'd0;
    endcase
  endfunction

  // Keeps only the right-justified bits that belong to the access size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 32'h0000_00FF;
      SIZE_HALF: return 32'h0000_FFFF;
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : load_extend                                                |
// | Zero- or sign-extends right-justified byte/halfword load data;       |
// | words pass through unchanged.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_extend
  import mem_defs::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  // Select the extension from the access size and signedness.
  always_comb begin
    o_data = i_data;
    case (i_size)
      SIZE_BYTE: o_data = i_signed ? {{24{i_data[7]}}, i_data[7:0]}
                                   : {24'b0, i_data[7:0]};
      SIZE_HALF: o_data = i_signed ? {{16{i_data[15]}}, i_data[15:0]}
                                   : {16'b0, i_data[15:0]};
      default:   o_data = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_access_ctrl                                            |
// | Single-outstanding load/store initiator for the big-endian 256-byte  |
// | data memory: legality check, timed memory access, extended response. |
// | Option  : MISALIGN_SPLIT_EN - misaligned in-range half/word accesses |
// |           run as sequential byte accesses instead of erroring.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_defs::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int MEM_BYTES   = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_en,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_lat;
  logic [1:0]    r_size;
  logic          r_write;
  logic          r_signed;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [1:0]    r_mem_size;
  logic          r_mem_rw;

  logic          w_accept;
  logic [2:0]    w_nbytes;
  logic [32:0]   w_end;
  logic          w_rsvd;
  logic          w_misal;
  logic          w_range;
  logic          w_err;
  logic          w_lat_last;
  logic [31:0]   w_ext_data;

  assign w_accept   = req_valid && req_ready;
  assign w_nbytes   = size_bytes(req_size);
  assign w_end      = {1'b0, req_addr} + {30'b0, w_nbytes};
  assign w_rsvd     = (req_size == SIZE_RSVD);
  assign w_misal    = ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == SIZE_HALF) && req_addr[0]);
  assign w_range    = (w_end > 33'(MEM_BYTES));
  assign w_lat_last = (r_lat == CW'(MEM_LATENCY - 1));

  load_extend u_ext (
    .i_data   (mem_rdata),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext_data)
  );

`ifdef MISALIGN_SPLIT_EN
  logic          w_split;
  logic [1:0]    w_blast;
  logic [31:0]   w_split_ext;
  logic [1:0]    r_bidx;
  logic [1:0]    r_blast;
  logic          r_gap;
  logic [23:0]   r_asm;
  logic [31:0]   r_wdata;

  // Byte k of a store, counted from the most significant byte of the size.
  function automatic logic [7:0] split_byte(input logic [31:0] d,
                                            input logic [1:0]  last,
                                            input logic [1:0]  k);
    logic [4:0] sh;
    sh = {2'(last - k), 3'b000};
    return 8'(d >> sh);
  endfunction

  assign w_split = w_misal && !w_rsvd && !w_range;
  assign w_err   = w_rsvd || w_range;
  assign w_blast = 2'(w_nbytes - 3'd1);

  // Earlier bytes are more significant: shift them up as each byte lands.
  load_extend u_ext_split (
    .i_data   ({r_asm, mem_rdata[7:0]}),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_split_ext)
  );

  // Split-access bookkeeping: byte index, inter-byte gap and assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bidx  <= 2'd0;
      r_blast <= 2'd0;
      r_gap   <= 1'b0;
      r_asm   <= 24'd0;
      r_wdata <= 32'd0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_bidx  <= 2'd0;
        r_blast <= w_blast;
        r_gap   <= 1'b0;
        r_asm   <= 24'd0;
        r_wdata <= req_wdata & size_mask(req_size);
      end
    end else if (r_state == ACCESS_SPLIT) begin
      if (r_gap) begin
        r_gap  <= 1'b0;
        r_bidx <= r_bidx + 2'd1;
      end else if (w_lat_last) begin
        r_asm <= {r_asm[15:0], mem_rdata[7:0]};
        r_gap <= (r_bidx != r_blast);
      end
    end
  end
`else
  assign w_err = w_rsvd || w_misal || w_range;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and handshake/strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_en      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_err) w_state_nxt = RESP;
`ifdef MISALIGN_SPLIT_EN
          else if (w_split) w_state_nxt = ACCESS_SPLIT;
`endif
          else w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        if (w_lat_last) w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      ACCESS_SPLIT: begin
`ifdef MISALIGN_SPLIT_EN
        mem_en = !r_gap;
        if (!r_gap && w_lat_last && (r_bidx == r_blast)) w_state_nxt = RESP;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, access timing and response data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat       <= '0;
      r_size      <= SIZE_WORD;
      r_write     <= 1'b0;
      r_signed    <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_size  <= SIZE_WORD;
      r_mem_rw    <= RW_READ;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lat       <= '0;
            r_size      <= req_size;
            r_write     <= req_write;
            r_signed    <= req_signed;
            r_rdata     <= 32'd0;
            r_err       <= w_err;
            r_mem_addr  <= req_addr;
            r_mem_size  <= req_size;
            r_mem_rw    <= req_write ? RW_WRITE : RW_READ;
            r_mem_wdata <= req_wdata & size_mask(req_size);
`ifdef MISALIGN_SPLIT_EN
            if (w_split) begin
              r_mem_size  <= SIZE_BYTE;
              r_mem_wdata <= {24'b0, split_byte(req_wdata & size_mask(req_size),
                                                w_blast, 2'd0)};
            end
`endif
          end
        end
        ACCESS: begin
          if (w_lat_last) begin
            r_lat <= '0;
            if (!r_write) r_rdata <= w_ext_data;
          end else begin
            r_lat <= r_lat + CW'(1);
          end
        end
`ifdef MISALIGN_SPLIT_EN
        ACCESS_SPLIT: begin
          if (r_gap) begin
            r_mem_addr  <= r_mem_addr + 32'd1;
            r_mem_wdata <= {24'b0, split_byte(r_wdata, r_blast, r_bidx + 2'd1)};
          end else if (w_lat_last) begin
            r_lat <= '0;
            if ((r_bidx == r_blast) && !r_write) r_rdata <= w_split_ext;
          end else begin
            r_lat <= r_lat + CW'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_size   = r_mem_size;
  assign mem_rw     = r_mem_rw;

endmodule
`default_nettype wire
